steer_issue: RTL and testbench
==============================

Name: steer_issue

Overview:
- Parametrised dual-issue steering stage between fetch and the two execution pipes.
- Pipe 0 is the branch pipe. Pipe 1 is the memory pipe. Either pipe executes ALU ops.
- Each cycle it classifies a fetched instruction pair, routes each instruction to a legal pipe, and tags both with program-order sequence IDs. Outputs are registered.
- When both instructions need the same pipe, it buffers the younger one in a hold register and back-pressures fetch. Optional single-issue mode.

Parameters:
INST_WIDTH, 32, instruction width
ADDR_WIDTH, 16, PC width
ID_WIDTH, 8, sequence ID width
OPCODE_MSB, 31, opcode field high bit
OPCODE_LSB, 26, opcode field low bit (field is 6 bits)
OP_CMP, 6'd10, cmp opcode (branch-class)
OP_TEST, 6'd11, test opcode (branch-class)
OP_CMPI, 6'd26, cmpi opcode (branch-class)
OP_TESTI, 6'd27, testi opcode (branch-class)
DUAL_ISSUE, 1, 1 = pair issue; 0 = one instruction per cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
stall  in  1  downstream freeze
flush  in  1  mispredict flush
fetch_valid  in  1  fetch pair valid
instruction0_in  in  INST_WIDTH  older fetched instruction
instruction1_in  in  INST_WIDTH  younger fetched instruction
pc_in  in  ADDR_WIDTH  PC of instruction0_in; instruction1 PC = pc_in+1 (mod 2^ADDR_WIDTH)
fetch_ready  out  1  pair accepted this cycle
instruction0_out  out  INST_WIDTH  pipe 0 instruction
instruction1_out  out  INST_WIDTH  pipe 1 instruction
pc0_out  out  ADDR_WIDTH  pipe 0 PC
pc1_out  out  ADDR_WIDTH  pipe 1 PC
valid0_out  out  1  pipe 0 slot valid
valid1_out  out  1  pipe 1 slot valid
instruction0_id  out  ID_WIDTH  pipe 0 sequence ID
instruction1_id  out  ID_WIDTH  pipe 1 sequence ID
first  out  1  1 = pipe 1 holds the older instruction

Behaviour:
- Classification by opcode:
  - 10xxxx → MEM.
  - 11xxxx, OP_CMP, OP_TEST, OP_CMPI, OP_TESTI → BR.
  - All else, including 000000 (NOP) → ALU.
- State machine: EMPTY or HOLD. HOLD owns a register holding the pending instruction, its PC and its class.
- fetch_ready = reset && !stall && !flush && state==EMPTY (combinational). A pair is accepted when fetch_valid && fetch_ready.
- Outputs register on the edge after acceptance, so latency is 1 cycle.
- Any slot with valid=0 drives instruction=0 (NOP), pc=0, id=0.
- Routing for an accepted pair, with DUAL_ISSUE=1. Slot order is (in0,in1):
  - Straight (in0→pipe0, in1→pipe1, first=0): (ALU,ALU), (BR,ALU), (BR,MEM), (ALU,MEM).
  - Swapped (in1→pipe0, in0→pipe1, first=1): (ALU,BR), (MEM,ALU), (MEM,BR).
  - Conflict (BR,BR): in0→pipe0 with valid1=0, first=0. in1 is latched into HOLD.
  - Conflict (MEM,MEM): in0→pipe1 with valid0=0, first=1. in1 is latched into HOLD.
- In HOLD (not stalled):
  - The pending instruction issues alone next edge: BR/ALU→pipe0, MEM→pipe1, first=(pipe==1).
  - State returns to EMPTY. fetch_ready stays 0 throughout HOLD.
- DUAL_ISSUE=0: every accepted pair behaves as a conflict. in0 issues alone to its class pipe (ALU→pipe0), then in1 issues from HOLD.
- fetch_valid=0 in EMPTY: both valids go 0 next edge.
- Sequence IDs:
  - An internal ID_WIDTH counter seq is reset to 0.
  - Issued instructions take consecutive IDs in program order: older gets seq, younger gets seq+1.
  - seq advances by the number issued (0/1/2) and wraps modulo 2^ID_WIDTH.
- stall=1: all registers, outputs, state and seq hold. No acceptance.
- Priority: reset > flush > stall.
- flush=1: state→EMPTY, HOLD contents discarded, both valids 0 next edge, seq held, no acceptance that cycle.
- Reset (reset=0):
  - State EMPTY, seq=0.
  - All instruction/pc/id outputs 0, valids 0, first 0.
  - fetch_ready=0 while reset is asserted.
  - Mid-HOLD reset discards the pending instruction.

Test Plan:
- Reset, then pair add(0x04000000), lw(0x80000000), pc_in=0x0010 → next edge: pipe0=add pc 0x0010 id0; pipe1=lw pc 0x0011 id1; first=0; both valid.
- lw(0x80000000), jmp(0xC0000000), pc_in=0x0020 → swapped: pipe0=jmp pc 0x0021 id1; pipe1=lw pc 0x0020 id0; first=1.
- jmp, jmp, pc_in=0x0030 → cycle 1: pipe0=jmp@0x0030, valid1=0, fetch_ready drops to 0. Cycle 2: pipe0=jmp@0x0031, id+1, fetch_ready=1.
- lw, lw in HOLD with stall=1 for 3 cycles → outputs and fetch_ready frozen. After release, the second lw issues on pipe1 with first=1.
- HOLD with flush=1 → valids 0 next edge, held instruction never issues, fetch_ready=1 the following cycle.
- DUAL_ISSUE=0 with add,add → two cycles, each on pipe0. ID counter at 8'hFF wraps to 8'h00 on the second issue.

Source files
------------

// File: rtl/steer_issue.sv
// Dual-issue steering stage: classifies a fetched instruction pair, routes
// each instruction to a legal pipe (pipe 0 = branch, pipe 1 = memory, ALU on
// either) and tags issued instructions with program-order sequence IDs.
// A same-pipe conflict parks the younger instruction in a one-entry hold
// register and back-pressures fetch until it has issued.
module steer_issue #(
    parameter int INST_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int ID_WIDTH         = 8,
    parameter int OPCODE_MSB       = 31,
    parameter int OPCODE_LSB       = 26,
    parameter logic [5:0] OP_CMP   = 6'd10,
    parameter logic [5:0] OP_TEST  = 6'd11,
    parameter logic [5:0] OP_CMPI  = 6'd26,
    parameter logic [5:0] OP_TESTI = 6'd27,
    parameter bit DUAL_ISSUE       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  fetch_valid,
    input  logic [INST_WIDTH-1:0] instruction0_in,
    input  logic [INST_WIDTH-1:0] instruction1_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  fetch_ready,
    output logic [INST_WIDTH-1:0] instruction0_out,
    output logic [INST_WIDTH-1:0] instruction1_out,
    output logic [ADDR_WIDTH-1:0] pc0_out,
    output logic [ADDR_WIDTH-1:0] pc1_out,
    output logic                  valid0_out,
    output logic                  valid1_out,
    output logic [ID_WIDTH-1:0]   instruction0_id,
    output logic [ID_WIDTH-1:0]   instruction1_id,
    output logic                  first
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MEM = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ID_WIDTH-1:0]   ID_ONE = {{(ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ID_WIDTH-1:0]   ID_TWO = {{(ID_WIDTH-2){1'b0}}, 2'b10};

    // Opcode class: 10xxxx memory, 11xxxx and compare/test forms branch, rest ALU.
    function automatic logic [1:0] classify(input logic [5:0] op);
        logic [1:0] cls;
        if (op[5:4] == 2'b10) begin
            cls = CLS_MEM;
        end else if ((op[5:4] == 2'b11) || (op == OP_CMP) || (op == OP_TEST) ||
                     (op == OP_CMPI) || (op == OP_TESTI)) begin
            cls = CLS_BR;
        end else begin
            cls = CLS_ALU;
        end
        return cls;
    endfunction

    logic                  state_r;
    logic [ID_WIDTH-1:0]   seq_r;
    logic [INST_WIDTH-1:0] hold_inst_r;
    logic [ADDR_WIDTH-1:0] hold_pc_r;
    logic [1:0]            hold_cls_r;

    logic [INST_WIDTH-1:0] inst0_r, inst1_r;
    logic [ADDR_WIDTH-1:0] pc0_r, pc1_r;
    logic [ID_WIDTH-1:0]   id0_r, id1_r;
    logic                  v0_r, v1_r, first_r;

    logic                  nxt_state_s;
    logic [ID_WIDTH-1:0]   nxt_seq_s;
    logic [INST_WIDTH-1:0] nxt_hold_inst_s;
    logic [ADDR_WIDTH-1:0] nxt_hold_pc_s;
    logic [1:0]            nxt_hold_cls_s;
    logic [INST_WIDTH-1:0] nxt_inst0_s, nxt_inst1_s;
    logic [ADDR_WIDTH-1:0] nxt_pc0_s, nxt_pc1_s;
    logic [ID_WIDTH-1:0]   nxt_id0_s, nxt_id1_s;
    logic                  nxt_v0_s, nxt_v1_s, nxt_first_s;

    logic [1:0]            cls0_s, cls1_s;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic                  accept_s;

    assign fetch_ready = reset && !stall && !flush && (state_r == ST_EMPTY);
    assign accept_s    = fetch_valid && fetch_ready;
    assign cls0_s      = classify(instruction0_in[OPCODE_MSB:OPCODE_LSB]);
    assign cls1_s      = classify(instruction1_in[OPCODE_MSB:OPCODE_LSB]);
    assign pc_next_s   = pc_in + PC_ONE;

    // Next-state routing: flush clears, HOLD drains, accepted pairs steer.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_seq_s       = seq_r;
        nxt_hold_inst_s = hold_inst_r;
        nxt_hold_pc_s   = hold_pc_r;
        nxt_hold_cls_s  = hold_cls_r;
        nxt_inst0_s     = '0;
        nxt_inst1_s     = '0;
        nxt_pc0_s       = '0;
        nxt_pc1_s       = '0;
        nxt_id0_s       = '0;
        nxt_id1_s       = '0;
        nxt_v0_s        = 1'b0;
        nxt_v1_s        = 1'b0;
        nxt_first_s     = 1'b0;
        if (flush) begin
            nxt_state_s     = ST_EMPTY;
            nxt_hold_inst_s = '0;
            nxt_hold_pc_s   = '0;
            nxt_hold_cls_s  = CLS_ALU;
        end else if (state_r == ST_HOLD) begin
            nxt_state_s = ST_EMPTY;
            nxt_seq_s   = seq_r + ID_ONE;
            if (hold_cls_r == CLS_MEM) begin
                nxt_inst1_s = hold_inst_r;
                nxt_pc1_s   = hold_pc_r;
                nxt_id1_s   = seq_r;
                nxt_v1_s    = 1'b1;
                nxt_first_s = 1'b1;
            end else begin
                nxt_inst0_s = hold_inst_r;
                nxt_pc0_s   = hold_pc_r;
                nxt_id0_s   = seq_r;
                nxt_v0_s    = 1'b1;
            end
        end else if (accept_s) begin
            if (!DUAL_ISSUE || ((cls0_s == cls1_s) && (cls0_s != CLS_ALU))) begin
                nxt_state_s     = ST_HOLD;
                nxt_seq_s       = seq_r + ID_ONE;
                nxt_hold_inst_s = instruction1_in;
                nxt_hold_pc_s   = pc_next_s;
                nxt_hold_cls_s  = cls1_s;
                if (cls0_s == CLS_MEM) begin
                    nxt_inst1_s = instruction0_in;
                    nxt_pc1_s   = pc_in;
                    nxt_id1_s   = seq_r;
                    nxt_v1_s    = 1'b1;
                    nxt_first_s = 1'b1;
                end else begin
                    nxt_inst0_s = instruction0_in;
                    nxt_pc0_s   = pc_in;
                    nxt_id0_s   = seq_r;
                    nxt_v0_s    = 1'b1;
                end
            end else if ((cls0_s != CLS_MEM) && (cls1_s != CLS_BR)) begin
                nxt_seq_s   = seq_r + ID_TWO;
                nxt_inst0_s = instruction0_in;
                nxt_pc0_s   = pc_in;
                nxt_id0_s   = seq_r;
                nxt_inst1_s = instruction1_in;
                nxt_pc1_s   = pc_next_s;
                nxt_id1_s   = seq_r + ID_ONE;
                nxt_v0_s    = 1'b1;
                nxt_v1_s    = 1'b1;
            end else begin
                nxt_seq_s   = seq_r + ID_TWO;
                nxt_inst0_s = instruction1_in;
                nxt_pc0_s   = pc_next_s;
                nxt_id0_s   = seq_r + ID_ONE;
                nxt_inst1_s = instruction0_in;
                nxt_pc1_s   = pc_in;
                nxt_id1_s   = seq_r;
                nxt_v0_s    = 1'b1;
                nxt_v1_s    = 1'b1;
                nxt_first_s = 1'b1;
            end
        end else begin
            nxt_state_s = ST_EMPTY;
        end
    end

    // State, hold entry, sequence counter and registered slot outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            seq_r       <= '0;
            hold_inst_r <= '0;
            hold_pc_r   <= '0;
            hold_cls_r  <= CLS_ALU;
            inst0_r     <= '0;
            inst1_r     <= '0;
            pc0_r       <= '0;
            pc1_r       <= '0;
            id0_r       <= '0;
            id1_r       <= '0;
            v0_r        <= 1'b0;
            v1_r        <= 1'b0;
            first_r     <= 1'b0;
        end else if (flush || !stall) begin
            state_r     <= nxt_state_s;
            seq_r       <= nxt_seq_s;
            hold_inst_r <= nxt_hold_inst_s;
            hold_pc_r   <= nxt_hold_pc_s;
            hold_cls_r  <= nxt_hold_cls_s;
            inst0_r     <= nxt_inst0_s;
            inst1_r     <= nxt_inst1_s;
            pc0_r       <= nxt_pc0_s;
            pc1_r       <= nxt_pc1_s;
            id0_r       <= nxt_id0_s;
            id1_r       <= nxt_id1_s;
            v0_r        <= nxt_v0_s;
            v1_r        <= nxt_v1_s;
            first_r     <= nxt_first_s;
        end else begin
            state_r     <= state_r;
            seq_r       <= seq_r;
        end
    end

    assign instruction0_out = inst0_r;
    assign instruction1_out = inst1_r;
    assign pc0_out          = pc0_r;
    assign pc1_out          = pc1_r;
    assign instruction0_id  = id0_r;
    assign instruction1_id  = id1_r;
    assign valid0_out       = v0_r;
    assign valid1_out       = v1_r;
    assign first            = first_r;

endmodule

// File: tb/tb_steer_issue.sv
// Directed bench for steer_issue: a dual-issue instance (u_dual) and a
// single-issue instance (u_single) sharing clock and reset.
module tb_steer_issue;

    localparam logic [31:0] ADD = 32'h0400_0000;
    localparam logic [31:0] LW  = 32'h8000_0000;
    localparam logic [31:0] JMP = 32'hC000_0000;
    localparam logic [31:0] CMP = 32'h2800_0000;

    logic        clk = 1'b0;
    logic        reset;
    int          n_cmp = 0;
    int          n_err = 0;

    // dual-issue instance signals
    logic        stall0, flush0, fv0, fr0;
    logic [31:0] in0_0, in1_0, i0_0, i1_0;
    logic [15:0] pc_0, pc0_0, pc1_0;
    logic [7:0]  id0_0, id1_0;
    logic        v0_0, v1_0, first_0;

    // single-issue instance signals
    logic        stall1, flush1, fv1, fr1;
    logic [31:0] in0_1, in1_1, i0_1, i1_1;
    logic [15:0] pc_1, pc0_1, pc1_1;
    logic [7:0]  id0_1, id1_1;
    logic        v0_1, v1_1, first_1;

    always #5 clk = ~clk;

    steer_issue u_dual (
        .clk(clk), .reset(reset), .stall(stall0), .flush(flush0),
        .fetch_valid(fv0), .instruction0_in(in0_0), .instruction1_in(in1_0),
        .pc_in(pc_0), .fetch_ready(fr0),
        .instruction0_out(i0_0), .instruction1_out(i1_0),
        .pc0_out(pc0_0), .pc1_out(pc1_0), .valid0_out(v0_0), .valid1_out(v1_0),
        .instruction0_id(id0_0), .instruction1_id(id1_0), .first(first_0)
    );

    steer_issue #(.DUAL_ISSUE(1'b0)) u_single (
        .clk(clk), .reset(reset), .stall(stall1), .flush(flush1),
        .fetch_valid(fv1), .instruction0_in(in0_1), .instruction1_in(in1_1),
        .pc_in(pc_1), .fetch_ready(fr1),
        .instruction0_out(i0_1), .instruction1_out(i1_1),
        .pc0_out(pc0_1), .pc1_out(pc1_1), .valid0_out(v0_1), .valid1_out(v1_1),
        .instruction0_id(id0_1), .instruction1_id(id1_1), .first(first_1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slots(input string tag, input bit sel,
                               input logic [31:0] e_i0, input logic [15:0] e_pc0,
                               input logic [7:0] e_id0, input logic e_v0,
                               input logic [31:0] e_i1, input logic [15:0] e_pc1,
                               input logic [7:0] e_id1, input logic e_v1,
                               input logic e_first);
        check_eq({tag, ".i0"},    sel ? i0_1    : i0_0,    e_i0);
        check_eq({tag, ".pc0"},   sel ? pc0_1   : pc0_0,   e_pc0);
        check_eq({tag, ".id0"},   sel ? id0_1   : id0_0,   e_id0);
        check_eq({tag, ".v0"},    sel ? v0_1    : v0_0,    e_v0);
        check_eq({tag, ".i1"},    sel ? i1_1    : i1_0,    e_i1);
        check_eq({tag, ".pc1"},   sel ? pc1_1   : pc1_0,   e_pc1);
        check_eq({tag, ".id1"},   sel ? id1_1   : id1_0,   e_id1);
        check_eq({tag, ".v1"},    sel ? v1_1    : v1_0,    e_v1);
        check_eq({tag, ".first"}, sel ? first_1 : first_0, e_first);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc);
        fv0 = v; in0_0 = a; in1_0 = b; pc_0 = pc;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc);
        fv1 = v; in0_1 = a; in1_1 = b; pc_1 = pc;
    endtask

    initial begin
        reset = 1'b0;
        stall0 = 1'b0; flush0 = 1'b0; stall1 = 1'b0; flush1 = 1'b0;
        drive0(1'b1, ADD, LW, 16'h0010);
        drive1(1'b0, 32'h0, 32'h0, 16'h0);
        repeat (3) tick();
        check_slots("reset", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        check_eq("reset.fr", fr0, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("post_reset.fr", fr0, 1'b1);

        // straight ALU,MEM
        tick();
        check_slots("straight", 1'b0, ADD, 16'h0010, 8'h00, 1'b1, LW, 16'h0011, 8'h01, 1'b1, 1'b0);

        // swapped MEM,BR
        drive0(1'b1, LW, JMP, 16'h0020);
        tick();
        check_slots("swap", 1'b0, JMP, 16'h0021, 8'h03, 1'b1, LW, 16'h0020, 8'h02, 1'b1, 1'b1);

        // BR,BR conflict then drain from hold
        drive0(1'b1, JMP, JMP, 16'h0030);
        tick();
        check_slots("brbr.c1", 1'b0, JMP, 16'h0030, 8'h04, 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        check_eq("brbr.c1.fr", fr0, 1'b0);
        drive0(1'b0, ADD, ADD, 16'h0000);
        tick();
        check_slots("brbr.c2", 1'b0, JMP, 16'h0031, 8'h05, 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        check_eq("brbr.c2.fr", fr0, 1'b1);

        // MEM,MEM conflict with a 3-cycle stall while holding
        drive0(1'b1, LW, LW, 16'h0040);
        tick();
        check_slots("memmem.c1", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, LW, 16'h0040, 8'h06, 1'b1, 1'b1);
        drive0(1'b0, ADD, ADD, 16'h0000);
        stall0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_slots("memmem.stall", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, LW, 16'h0040, 8'h06, 1'b1, 1'b1);
            check_eq("memmem.stall.fr", fr0, 1'b0);
        end
        stall0 = 1'b0;
        tick();
        check_slots("memmem.c2", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, LW, 16'h0041, 8'h07, 1'b1, 1'b1);

        // flush while holding discards the pending instruction
        drive0(1'b1, JMP, JMP, 16'h0050);
        tick();
        check_slots("flush.c1", 1'b0, JMP, 16'h0050, 8'h08, 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        drive0(1'b0, ADD, ADD, 16'h0000);
        flush0 = 1'b1;
        #1;
        check_eq("flush.fr_low", fr0, 1'b0);
        tick();
        check_slots("flush.c2", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        flush0 = 1'b0;
        #1;
        check_eq("flush.fr_back", fr0, 1'b1);

        // ALU,ALU with PC wrap; seq held over flush so ids continue at 9
        drive0(1'b1, ADD, ADD, 16'hFFFF);
        tick();
        check_slots("pcwrap", 1'b0, ADD, 16'hFFFF, 8'h09, 1'b1, ADD, 16'h0000, 8'h0A, 1'b1, 1'b0);

        // ALU,cmp: cmp is branch-class so the pair swaps
        drive0(1'b1, ADD, CMP, 16'h0070);
        tick();
        check_slots("cmp", 1'b0, CMP, 16'h0071, 8'h0C, 1'b1, ADD, 16'h0070, 8'h0B, 1'b1, 1'b1);

        // idle fetch
        drive0(1'b0, ADD, ADD, 16'h0000);
        tick();
        check_slots("idle", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);

        // reset during HOLD drops the pending instruction
        drive0(1'b1, JMP, JMP, 16'h0080);
        tick();
        drive0(1'b0, ADD, ADD, 16'h0000);
        reset = 1'b0;
        tick();
        check_slots("midreset", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_slots("midreset.after", 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);

        // single-issue: advance seq to 0xFE with 127 pairs
        for (int k = 0; k < 127; k++) begin
            drive1(1'b1, ADD, ADD, 16'h0000);
            tick();
            drive1(1'b0, ADD, ADD, 16'h0000);
            tick();
        end
        drive1(1'b1, LW, ADD, 16'h0100);
        tick();
        check_slots("single.lw", 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, LW, 16'h0100, 8'hFE, 1'b1, 1'b1);
        drive1(1'b0, ADD, ADD, 16'h0000);
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        drive1(1'b1, ADD, ADD, 16'h0200);
        tick();
        check_slots("single.a0", 1'b1, ADD, 16'h0200, 8'hFF, 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        check_eq("single.a0.fr", fr1, 1'b0);
        drive1(1'b0, ADD, ADD, 16'h0000);
        tick();
        check_slots("single.a1", 1'b1, ADD, 16'h0201, 8'h00, 1'b1, 32'h0, 16'h0, 8'h0, 1'b0, 1'b0);
        check_eq("single.a1.fr", fr1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
